// File: rtl/lcd_read_ctrl_if.sv
// Bus-side signal bundle for lcd_read_ctrl: start/length/abort request, LCD data
// pins, read strobe, bus-direction control and the per-word / per-transaction results.
interface lcd_read_ctrl_if #(
   parameter int DW = 16
);
   logic          rd_start_i;
   logic [7:0]    rd_len_i;
   logic          abort_i;
   logic [DW-1:0] lcd_db_i;
   logic          rd_n;
   logic          db_oe_o;
   logic [DW-1:0] data_o;
   logic          data_vld_o;
   logic          busy_o;
   logic          done_o;

   modport slave (
      input  rd_start_i, rd_len_i, abort_i, lcd_db_i,
      output rd_n, db_oe_o, data_o, data_vld_o, busy_o, done_o
   );

   modport master (
      output rd_start_i, rd_len_i, abort_i, lcd_db_i,
      input  rd_n, db_oe_o, data_o, data_vld_o, busy_o, done_o
   );
endinterface

// File: rtl/lcd_read_ctrl.sv
// 8080-style LCD read strobe controller: releases the bus, issues rd_n strobes and
// samples lcd_db_i at the end of each low phase. Optional macro: LCD_RD_DUMMY_EN.
module lcd_read_ctrl #(
   parameter int DW          = 16,
   parameter int TURN_CYC    = 2,
   parameter int RD_LOW_CYC  = 4,
   parameter int RD_HIGH_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   lcd_read_ctrl_if.slave    bus
);

`ifdef LCD_RD_DUMMY_EN
   localparam bit DUMMY_EN = 1'b1;
`else
   localparam bit DUMMY_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TURN = 3'd1,
      RD_L = 3'd2,
      RD_H = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t        state;
   logic [7:0]    phase_cnt;
   logic [7:0]    word_cnt;
   logic          dummy_pend;
   logic          rd_n_r;
   logic          db_oe_r;
   logic [DW-1:0] data_r;
   logic          vld_r;
   logic          busy_r;
   logic          done_r;

   assign bus.rd_n       = rd_n_r;
   assign bus.db_oe_o    = db_oe_r;
   assign bus.data_o     = data_r;
   assign bus.data_vld_o = vld_r;
   assign bus.busy_o     = busy_r;
   assign bus.done_o     = done_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase_cnt  <= '0;
         word_cnt   <= '0;
         dummy_pend <= 1'b0;
         rd_n_r     <= 1'b1;
         db_oe_r    <= 1'b1;
         data_r     <= '0;
         vld_r      <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         vld_r  <= 1'b0;
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               rd_n_r  <= 1'b1;
               db_oe_r <= 1'b1;
               busy_r  <= 1'b0;
               if (bus.rd_start_i) begin
                  word_cnt   <= bus.rd_len_i;
                  dummy_pend <= DUMMY_EN;
                  busy_r     <= 1'b1;
                  if (bus.rd_len_i == 8'd0) begin
                     // Empty read: report completion without ever releasing the bus.
                     state  <= DONE;
                     done_r <= 1'b1;
                  end else begin
                     state     <= TURN;
                     db_oe_r   <= 1'b0;
                     phase_cnt <= 8'(TURN_CYC - 1);
                  end
               end
            end
            TURN: begin
               if (bus.abort_i) begin
                  state  <= DONE;
                  done_r <= 1'b1;
               end else if (phase_cnt == 8'd0) begin
                  state     <= RD_L;
                  rd_n_r    <= 1'b0;
                  phase_cnt <= 8'(RD_LOW_CYC - 1);
               end else begin
                  phase_cnt <= phase_cnt - 8'd1;
               end
            end
            RD_L: begin
               if (bus.abort_i) begin
                  state  <= DONE;
                  rd_n_r <= 1'b1;
                  done_r <= 1'b1;
               end else if (phase_cnt == 8'd0) begin
                  state     <= RD_H;
                  rd_n_r    <= 1'b1;
                  phase_cnt <= 8'(RD_HIGH_CYC - 1);
                  // A dummy strobe consumes bus time but neither data nor a word slot.
                  if (dummy_pend) begin
                     dummy_pend <= 1'b0;
                  end else begin
                     data_r   <= bus.lcd_db_i;
                     vld_r    <= 1'b1;
                     word_cnt <= word_cnt - 8'd1;
                  end
               end else begin
                  phase_cnt <= phase_cnt - 8'd1;
               end
            end
            RD_H: begin
               if (bus.abort_i) begin
                  state  <= DONE;
                  done_r <= 1'b1;
               end else if (phase_cnt == 8'd0) begin
                  if (word_cnt != 8'd0) begin
                     state     <= RD_L;
                     rd_n_r    <= 1'b0;
                     phase_cnt <= 8'(RD_LOW_CYC - 1);
                  end else begin
                     state  <= DONE;
                     done_r <= 1'b1;
                  end
               end else begin
                  phase_cnt <= phase_cnt - 8'd1;
               end
            end
            DONE: begin
               state     <= IDLE;
               rd_n_r    <= 1'b1;
               db_oe_r   <= 1'b1;
               busy_r    <= 1'b0;
               phase_cnt <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Directed self-checking bench for lcd_read_ctrl (default parameters); expectations
// follow the cycle numbering where the start is sampled at edge 0.
module tb_lcd_read_ctrl;
   localparam int DW   = 16;
   localparam int TC   = 2;
   localparam int LC   = 4;
   localparam int HC   = 2;
   localparam int PER  = LC + HC;
`ifdef LCD_RD_DUMMY_EN
   localparam int DUM = 1;
`else
   localparam int DUM = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   logic [DW-1:0] words [8];
   logic [DW-1:0] last_data;

   lcd_read_ctrl_if #(.DW(DW)) bus_if ();

   lcd_read_ctrl #(.DW(DW), .TURN_CYC(TC), .RD_LOW_CYC(LC), .RD_HIGH_CYC(HC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rd_n"},  32'(bus_if.rd_n), 32'd1);
      chk({tag, "_oe"},    32'(bus_if.db_oe_o), 32'd1);
      chk({tag, "_busy"},  32'(bus_if.busy_o), 32'd0);
      chk({tag, "_done"},  32'(bus_if.done_o), 32'd0);
      chk({tag, "_vld"},   32'(bus_if.data_vld_o), 32'd0);
   endtask

   // Entered at the negedge of cycle 0; returns at the negedge of the first IDLE cycle.
   task automatic txn(input string tag, input int n, input int abort_at, input int exp_vld);
      int d, s, blen, p, k, off, nvld;
      logic e_rd, e_vld;
      d    = (n > 0) ? DUM : 0;
      s    = (n > 0) ? n + d : 0;
      blen = (n > 0) ? TC + s * PER + 1 : 1;
      if (abort_at > 0) blen = abort_at + 1;
      nvld = 0;
      bus_if.rd_start_i = 1'b1;
      bus_if.rd_len_i   = 8'(n);
      for (int c = 1; c <= blen + 1; c++) begin
         @(negedge clk);
         bus_if.rd_start_i = (c == 5);
         bus_if.rd_len_i   = 8'd7;
         bus_if.abort_i    = (c == abort_at);
         e_rd  = 1'b1;
         e_vld = 1'b0;
         p = c - TC - 1;
         k = (p >= 0) ? p / PER : 0;
         off = (p >= 0) ? p % PER : 0;
         if (c < blen && p >= 0) begin
            e_rd  = (off < LC) ? 1'b0 : 1'b1;
            e_vld = (off == LC) && (k >= d);
         end
         if (c <= blen) begin
            chk({tag, "_rd_n"}, 32'(bus_if.rd_n), 32'(e_rd));
            chk({tag, "_busy"}, 32'(bus_if.busy_o), 32'd1);
            chk({tag, "_oe"},   32'(bus_if.db_oe_o), (n == 0) ? 32'd1 : 32'd0);
            chk({tag, "_done"}, 32'(bus_if.done_o), 32'(c == blen));
            chk({tag, "_vld"},  32'(bus_if.data_vld_o), 32'(e_vld));
            if (e_vld) begin
               chk({tag, "_data"}, 32'(bus_if.data_o), 32'(words[k - d]));
               last_data = words[k - d];
            end
         end else begin
            chk_idle({tag, "_after"});
            chk({tag, "_hold"}, 32'(bus_if.data_o), 32'(last_data));
         end
         if (bus_if.data_vld_o) nvld++;
         // Bus only carries the real word in the last low cycle, to catch early sampling.
         bus_if.lcd_db_i = 16'h5555;
         if (c < blen && p >= 0 && off == LC - 1)
            bus_if.lcd_db_i = (k >= d) ? words[k - d] : 16'h0000;
      end
      chk({tag, "_nvld"}, 32'(nvld), 32'(exp_vld));
      bus_if.rd_start_i = 1'b0;
      bus_if.abort_i    = 1'b0;
   endtask

   initial begin
      int rst_at;
      bus_if.rd_start_i = 1'b0;
      bus_if.rd_len_i   = 8'd0;
      bus_if.abort_i    = 1'b0;
      bus_if.lcd_db_i   = '0;
      last_data = '0;
      words[0] = 16'hA1B2; words[1] = 16'hC3D4; words[2] = 16'hE5F6; words[3] = 16'h1234;
      words[4] = 16'h9341; words[5] = 16'h0F0F; words[6] = 16'hBEEF; words[7] = 16'h7E57;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_idle("reset");
      chk("reset_data", 32'(bus_if.data_o), 32'd0);
      @(negedge clk);

      txn("n3", 3, 0, 3);
      txn("n0", 0, 0, 0);

      words[0] = 16'h9341;
      txn("n1", 1, 0, 1);

      words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
      txn("abort", 4, TC + 1 + PER * (1 + DUM) + 1, 1);

      // Reset during the second word's low phase, with a start pulsed while busy.
      rst_at = TC + 1 + PER * (1 + DUM) + 1;
      bus_if.rd_start_i = 1'b1;
      bus_if.rd_len_i   = 8'd3;
      for (int c = 1; c <= rst_at; c++) begin
         @(negedge clk);
         bus_if.rd_start_i = (c == 5);
         bus_if.lcd_db_i   = 16'hCAFE;
      end
      chk("rst_pre_rd_n", 32'(bus_if.rd_n), 32'd0);
      chk("rst_pre_data", 32'(bus_if.data_o), 32'hCAFE);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("rst_mid");
      chk("rst_mid_data", 32'(bus_if.data_o), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         chk_idle("rst_quiet");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end
endmodule

// File: doc/lcd_read_ctrl.md
# lcd_read_ctrl

Read-side strobe controller for the 8080-style parallel LCD bus, the counterpart to the write controller that drives `wr_n`. On a start request it releases the data bus and generates a programmed number of `rd_n` low/high strobes. It samples `lcd_db_i` at the end of each low phase and presents each word with a one-cycle valid pulse. It sits between the bus master (ID/status/GRAM readback) and the LCD pins, sharing the data bus with the write path through `db_oe_o`.

## Interface
- `DW`, 16, data bus width
- `TURN_CYC`, 2, bus turnaround cycles between bus release and the first `rd_n` fall (min 1)
- `RD_LOW_CYC`, 4, cycles `rd_n` is held low per word (min 1)
- `RD_HIGH_CYC`, 2, cycles `rd_n` is held high after each low phase (min 1)

- `clk`  in  1  system clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `rd_start_i`  in  1  start request; sampled only in IDLE
- `rd_len_i`  in  8  number of words to deliver; captured with `rd_start_i`
- `abort_i`  in  1  terminate the current transaction
- `lcd_db_i`  in  DW  LCD data bus input
- `rd_n`  out  1  LCD read strobe, active low
- `db_oe_o`  out  1  1 = host drives bus (write path), 0 = bus released to LCD
- `data_o`  out  DW  last sampled word
- `data_vld_o`  out  1  one-cycle pulse, `data_o` is new
- `busy_o`  out  1  high in every state except IDLE
- `done_o`  out  1  one-cycle pulse at transaction end

## Operation
- All outputs are registered. Reset values: `rd_n`=1, `db_oe_o`=1, `data_o`=0, `data_vld_o`=0, `busy_o`=0, `done_o`=0. The state machine resets to IDLE and all counters reset to 0.
- States: IDLE, TURN, RD_L, RD_H, DONE.
- IDLE: when `rd_start_i`=1, capture `rd_len_i` into the word counter.
  - Length 0 goes directly to DONE, with no strobes and `db_oe_o` held at 1.
  - Any other length goes to TURN.
- TURN: `db_oe_o`=0, `rd_n`=1 for TURN_CYC cycles, then goes to RD_L.
- RD_L: `rd_n`=0 for RD_LOW_CYC cycles. At the edge ending the last RD_L cycle:
  - `lcd_db_i` is registered into `data_o`.
  - `data_vld_o` is set for one cycle, unless the strobe is a dummy strobe (see Configuration).
  - Then the state goes to RD_H.
- RD_H: `rd_n`=1 for RD_HIGH_CYC cycles, then either:
  - back to RD_L if words remain, or
  - to DONE.
- DONE: one cycle. `done_o`=1, `rd_n`=1, `db_oe_o`=0. Next state is IDLE, and `db_oe_o` returns to 1 on entry to IDLE.
- `rd_start_i` asserted in any state other than IDLE is ignored (not queued).
- `abort_i` in TURN, RD_L or RD_H:
  - Next state is DONE, with `rd_n`=1 at that edge.
  - A word whose low phase is cut short is not sampled, so no `data_vld_o` for it.
  - `abort_i` is ignored in IDLE and DONE.
- `abort_i` has priority over normal phase progression. `rst` has priority over everything.
- `rst` mid-transaction: all outputs return to their reset values at the next edge. There is no `done_o` and no `data_vld_o`.
- `data_o` holds its value between words and after DONE.

## Timing
- Start sampled at edge 0. TURN occupies cycles 1..TURN_CYC, and the first `rd_n` low is in cycle TURN_CYC+1.
- Per-word strobe period: RD_LOW_CYC+RD_HIGH_CYC cycles.
- The LCD has RD_LOW_CYC cycles of access time. Data is sampled at the edge ending the last cycle that `rd_n` is low. `data_vld_o` is high during the first RD_H cycle of that word.
- `busy_o` duration: TURN_CYC + S·(RD_LOW_CYC+RD_HIGH_CYC) + 1 cycles, where S is the strobe count. With defaults and N=3, S=3: 2+18+1 = 21 cycles.
- Back-to-back transactions: IDLE lasts at least 1 cycle between DONE and the next accepted start.

## Configuration
- `LCD_RD_DUMMY_EN` defined:
  - The first strobe of every transaction with N≥1 is a dummy read, as required by controllers that return stale data on the first read after a command.
  - The dummy strobe is full-length, but its data is not presented: no `data_vld_o`, `data_o` unchanged.
  - S = N+1.
- `LCD_RD_DUMMY_EN` undefined: S = N. Every strobe produces a `data_vld_o`.
- N=0 produces no strobes in either configuration.

## Test plan
- Reset, then `rd_len_i`=3 with `lcd_db_i` changing to 16'hA1B2/16'hC3D4/16'hE5F6 during each low phase (no dummy, defaults):
  - three `rd_n` pulses, each 4 low / 2 high
  - `data_vld_o` in cycles 7, 13, 19 with those values
  - `done_o` in cycle 21, `busy_o` high for 21 cycles.
- `LCD_RD_DUMMY_EN` defined, `rd_len_i`=1, `lcd_db_i`=16'h0000 then 16'h9341:
  - two strobes
  - one `data_vld_o` only, `data_o`=16'h9341.
- `rd_len_i`=0: `done_o` one cycle after start, `rd_n` stays 1, `db_oe_o` stays 1.
- `abort_i` in the 2nd cycle of the second word's RD_L (N=4):
  - `rd_n`=1 next edge, exactly 1 `data_vld_o`, `done_o` one cycle later, then IDLE.
- `rst` asserted during RD_L of word 2, with `rd_start_i` pulsed while busy:
  - all outputs at reset values next edge, no `done_o`
  - the start pulsed while busy never triggers a transaction.
